// File: rtl/kv_cache_pkg.sv
// kv_cache_pkg: shared definitions for the cache miss controller slice.
//   WAYS / IDX_W / BEATS : default geometry (4 ways, 16 sets, 4 words/line)
//   way_t                : one-hot way vector
//   state_e              : miss-sequencing FSM states (fixed legacy encodings)
package kv_cache_pkg;

  localparam int unsigned WAYS  = 4;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned BEATS = 4;

  typedef logic [WAYS-1:0] way_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WB_CMD  = 3'd1,
    ST_WB_DATA = 3'd2,
    ST_RF_CMD  = 3'd3,
    ST_RF_DATA = 3'd4,
    ST_FILL    = 3'd5
  } state_e;

endpackage

// File: rtl/kv_cache_miss_ctrl_victim.sv
// kv_victim_select: combinational replacement-way picker.
//   i_valid_way    : per-way valid bits of the indexed set
//   i_lru_killmask : LRU victim suggestion (expected one-hot)
//   o_victim       : one-hot victim; the lowest invalid way if any exists,
//                    otherwise the lowest set bit of the killmask
module kv_victim_select #(
  parameter int unsigned WAYS = kv_cache_pkg::WAYS
) (
  input  logic [WAYS-1:0] i_valid_way,
  input  logic [WAYS-1:0] i_lru_killmask,
  output logic [WAYS-1:0] o_victim
);

  logic found;

  always_comb begin
    o_victim = '0;
    found    = 1'b0;
    if (!(&i_valid_way)) begin
      for (int unsigned i = 0; i < WAYS; i++) begin
        if (!found && !i_valid_way[i]) begin
          o_victim[i] = 1'b1;
          found       = 1'b1;
        end
      end
    end else begin
      // A malformed (multi-hot) killmask still yields a single victim.
      for (int unsigned i = 0; i < WAYS; i++) begin
        if (!found && i_lru_killmask[i]) begin
          o_victim[i] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/kv_cache_miss_ctrl.sv
// kv_cache_miss_ctrl: request sequencer for a set-associative cache.
// Hits become a one-cycle-later LRU touch + done pulse. Misses pick a victim,
// optionally write a dirty victim back, refill the line beat by beat, then
// write the tag and touch the LRU for the filled way.
//
// Build option: define KV_CACHE_WB_EN for write-back; when undefined the
// cache is write-through (no writeback states, dirty bits ignored).
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_req_valid / o_req_ready    lookup-result handshake
//   i_req_index, i_hit_way, i_valid_way, i_dirty_way, i_lru_killmask
//   o_lru_touch/_index/_way      LRU update strobe
//   o_mem_cmd_valid/_write/_index, i_mem_cmd_ready   line command
//   o_mem_wvalid / i_mem_wready  writeback beats
//   i_mem_rvalid                 refill beats (no backpressure)
//   o_data_way/_beat/_we         data-array way, beat select, refill write
//   o_tag_we                     tag/valid write for o_data_way
//   o_done, o_done_way           completion pulse
module kv_cache_miss_ctrl
  import kv_cache_pkg::*;
#(
  parameter int unsigned WAYS  = kv_cache_pkg::WAYS,
  parameter int unsigned IDX_W = kv_cache_pkg::IDX_W,
  parameter int unsigned BEATS = kv_cache_pkg::BEATS
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic [IDX_W-1:0]           i_req_index,
  input  logic [WAYS-1:0]            i_hit_way,
  input  logic [WAYS-1:0]            i_valid_way,
  input  logic [WAYS-1:0]            i_dirty_way,
  input  logic [WAYS-1:0]            i_lru_killmask,
  output logic                       o_lru_touch,
  output logic [IDX_W-1:0]           o_lru_index,
  output logic [WAYS-1:0]            o_lru_way,
  output logic                       o_mem_cmd_valid,
  input  logic                       i_mem_cmd_ready,
  output logic                       o_mem_cmd_write,
  output logic [IDX_W-1:0]           o_mem_cmd_index,
  output logic                       o_mem_wvalid,
  input  logic                       i_mem_wready,
  input  logic                       i_mem_rvalid,
  output logic [WAYS-1:0]            o_data_way,
  output logic [$clog2(BEATS)-1:0]   o_data_beat,
  output logic                       o_data_we,
  output logic                       o_tag_we,
  output logic                       o_done,
  output logic [WAYS-1:0]            o_done_way
);

  localparam int unsigned BW = $clog2(BEATS);

  state_e            state_q, state_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WAYS-1:0]   vict_q, vict_d;
  logic              hit_q, hit_d;
  logic [WAYS-1:0]   hit_way_q, hit_way_d;
  logic [IDX_W-1:0]  hit_idx_q, hit_idx_d;

  logic [WAYS-1:0]   sel_way;
  logic              accept;
  logic              is_hit;
  logic              last_beat;
  logic              fill;

`ifndef KV_CACHE_WB_EN
  logic unused_wt;
  assign unused_wt = (^i_dirty_way) ^ i_mem_wready;
`endif

  kv_victim_select #(
    .WAYS (WAYS)
  ) u_victim (
    .i_valid_way    (i_valid_way),
    .i_lru_killmask (i_lru_killmask),
    .o_victim       (sel_way)
  );

  assign accept    = i_req_valid && (state_q == ST_IDLE);
  assign is_hit    = |i_hit_way;
  assign last_beat = (cnt_q == BW'(BEATS - 1));
  assign fill      = (state_q == ST_FILL);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    vict_d    = vict_q;
    // Hit bookkeeping is a one-cycle pipeline: cleared unless a hit is accepted.
    hit_d     = accept && is_hit;
    hit_way_d = (accept && is_hit) ? i_hit_way : '0;
    hit_idx_d = (accept && is_hit) ? i_req_index : '0;

    case (state_q)
      ST_IDLE: begin
        if (accept && !is_hit) begin
          idx_d  = i_req_index;
          vict_d = sel_way;
          cnt_d  = '0;
`ifdef KV_CACHE_WB_EN
          state_d = (|(sel_way & i_valid_way & i_dirty_way)) ? ST_WB_CMD : ST_RF_CMD;
`else
          state_d = ST_RF_CMD;
`endif
        end
      end
`ifdef KV_CACHE_WB_EN
      ST_WB_CMD: begin
        if (i_mem_cmd_ready) begin
          state_d = ST_WB_DATA;
          cnt_d   = '0;
        end
      end
      ST_WB_DATA: begin
        if (i_mem_wready) begin
          cnt_d = cnt_q + BW'(1);
          if (last_beat) state_d = ST_RF_CMD;
        end
      end
`endif
      ST_RF_CMD: begin
        if (i_mem_cmd_ready) begin
          state_d = ST_RF_DATA;
          cnt_d   = '0;
        end
      end
      ST_RF_DATA: begin
        if (i_mem_rvalid) begin
          cnt_d = cnt_q + BW'(1);
          if (last_beat) state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      vict_q    <= '0;
      hit_q     <= 1'b0;
      hit_way_q <= '0;
      hit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      vict_q    <= vict_d;
      hit_q     <= hit_d;
      hit_way_q <= hit_way_d;
      hit_idx_q <= hit_idx_d;
    end
  end

  // A hit pulse and FILL never coincide: a miss leaves IDLE on accept, so no
  // hit can be pending while the miss is in flight.
  always_comb begin
    o_req_ready     = (state_q == ST_IDLE);
    o_lru_touch     = hit_q || fill;
    o_lru_way       = fill ? vict_q : hit_way_q;
    o_lru_index     = fill ? idx_q : hit_idx_q;
    o_done          = hit_q || fill;
    o_done_way      = fill ? vict_q : hit_way_q;
`ifdef KV_CACHE_WB_EN
    o_mem_cmd_valid = (state_q == ST_WB_CMD) || (state_q == ST_RF_CMD);
    o_mem_cmd_write = (state_q == ST_WB_CMD);
    o_mem_wvalid    = (state_q == ST_WB_DATA);
`else
    o_mem_cmd_valid = (state_q == ST_RF_CMD);
    o_mem_cmd_write = 1'b0;
    o_mem_wvalid    = 1'b0;
`endif
    o_mem_cmd_index = o_mem_cmd_valid ? idx_q : '0;
    o_data_way      = (state_q != ST_IDLE) ? vict_q : '0;
    o_data_beat     = cnt_q;
    o_data_we       = (state_q == ST_RF_DATA) && i_mem_rvalid;
    o_tag_we        = fill;
  end

endmodule

// File: tb/tb_kv_cache_miss_ctrl.sv
module tb_kv_cache_miss_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_index;
  logic [3:0] hit_way, valid_way, dirty_way, killmask;
  logic       lru_touch;
  logic [3:0] lru_index, lru_way;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_index;
  logic       wvalid, wready, rvalid;
  logic [3:0] data_way;
  logic [1:0] data_beat;
  logic       data_we, tag_we, done;
  logic [3:0] done_way;

  int checks = 0;
  int errors = 0;

  // scoreboard queues: done {idx,way}, refill beat numbers, tag-write ways
  int done_q[$];
  int beat_q[$];
  int tag_q[$];

  always #5 clk = ~clk;

  kv_cache_miss_ctrl #(.WAYS(4), .IDX_W(4), .BEATS(4)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_index     (req_index),
    .i_hit_way       (hit_way),
    .i_valid_way     (valid_way),
    .i_dirty_way     (dirty_way),
    .i_lru_killmask  (killmask),
    .o_lru_touch     (lru_touch),
    .o_lru_index     (lru_index),
    .o_lru_way       (lru_way),
    .o_mem_cmd_valid (cmd_valid),
    .i_mem_cmd_ready (cmd_ready),
    .o_mem_cmd_write (cmd_write),
    .o_mem_cmd_index (cmd_index),
    .o_mem_wvalid    (wvalid),
    .i_mem_wready    (wready),
    .i_mem_rvalid    (rvalid),
    .o_data_way      (data_way),
    .o_data_beat     (data_beat),
    .o_data_we       (data_we),
    .o_tag_we        (tag_we),
    .o_done          (done),
    .o_done_way      (done_way)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model_victim(input logic [3:0] v, input logic [3:0] k);
    logic [3:0] r;
    r = 4'b0000;
    if (v != 4'b1111) begin
      for (int i = 3; i >= 0; i--) if (!v[i]) r = 4'b0001 << i;
    end else begin
      for (int i = 3; i >= 0; i--) if (k[i]) r = 4'b0001 << i;
    end
    return r;
  endfunction

  // output monitor: samples mid-cycle, pops scoreboard entries
  always @(negedge clk) begin
    if (!rst) begin
      if (done || lru_touch) begin
        check("touch_vs_done", {31'd0, lru_touch}, {31'd0, done});
        check("lru_way_vs_done_way", {28'd0, lru_way}, {28'd0, done_way});
        if (done_q.size() == 0) check("done_extra", done_q.size(), 1);
        else begin
          int e;
          e = done_q.pop_front();
          check("done_way", {28'd0, done_way}, e & 15);
          check("lru_index", {28'd0, lru_index}, (e >> 4) & 15);
        end
      end
      if (data_we) begin
        if (beat_q.size() == 0) check("data_we_extra", beat_q.size(), 1);
        else check("refill_beat", {30'd0, data_beat}, beat_q.pop_front());
      end
      if (tag_we) begin
        if (tag_q.size() == 0) check("tag_we_extra", tag_q.size(), 1);
        else check("tag_way", {28'd0, data_way}, tag_q.pop_front());
      end
    end
  end

  task automatic serve_cmd(input logic exp_write, input logic [3:0] idx, input int dly);
    for (int n = 0; n < 20 && !cmd_valid; n++) tick();
    check("cmd_valid", {31'd0, cmd_valid}, 1);
    check("cmd_write", {31'd0, cmd_write}, {31'd0, exp_write});
    check("cmd_index", {28'd0, cmd_index}, {28'd0, idx});
    for (int d = 0; d < dly; d++) begin
      tick();
      check("cmd_hold_valid", {31'd0, cmd_valid}, 1);
      check("cmd_hold_write", {31'd0, cmd_write}, {31'd0, exp_write});
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("cmd_drop", {31'd0, cmd_valid}, 0);
  endtask

  task automatic write_beats(input int stall_beat);
    for (int b = 0; b < 4; b++) begin
      check("wvalid", {31'd0, wvalid}, 1);
      check("wb_beat", {30'd0, data_beat}, b);
      if (b == stall_beat) begin
        cmd_ready = 1'b1;  // irrelevant in the data phase, must not advance
        tick();
        cmd_ready = 1'b0;
        check("wb_stall_beat", {30'd0, data_beat}, b);
        check("wb_stall_wvalid", {31'd0, wvalid}, 1);
      end
      wready = 1'b1;
      tick();
      wready = 1'b0;
    end
    check("wvalid_drop", {31'd0, wvalid}, 0);
  endtask

  task automatic run_miss(input logic [3:0] idx, input logic [3:0] v, input logic [3:0] d,
                          input logic [3:0] k, input int dly, input int stall_beat,
                          input int rst_after, input bit hold);
    logic [3:0] vic;
    logic       wb;
    vic = model_victim(v, k);
`ifdef KV_CACHE_WB_EN
    wb = |(vic & v & d);
`else
    wb = 1'b0;
`endif
    req_valid = 1'b1; req_index = idx; hit_way = 4'b0000;
    valid_way = v; dirty_way = d; killmask = k;
    for (int n = 0; n < 30 && !req_ready; n++) tick();
    check("miss_req_ready", {31'd0, req_ready}, 1);
    done_q.push_back({idx, vic});
    tag_q.push_back(vic);
    for (int b = 0; b < 4; b++) beat_q.push_back(b);
    tick();
    if (hold) begin
      req_index = 4'd9; hit_way = 4'b0010;  // next request stays offered
    end else begin
      req_valid = 1'b0;
    end
    check("miss_data_way", {28'd0, data_way}, {28'd0, vic});
    check("busy_not_ready", {31'd0, req_ready}, 0);
    if (wb) begin
      serve_cmd(1'b1, idx, dly);
      write_beats(stall_beat);
      serve_cmd(1'b0, idx, 0);
    end else begin
      check("no_wvalid", {31'd0, wvalid}, 0);
      serve_cmd(1'b0, idx, dly);
    end
    for (int b = 0; b < 4; b++) begin
      if (b == rst_after) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        done_q.delete(); tag_q.delete(); beat_q.delete();
        check("rst_ready", {31'd0, req_ready}, 1);
        check("rst_beat", {30'd0, data_beat}, 0);
        check("rst_data_way", {28'd0, data_way}, 0);
        check("rst_tag_we", {31'd0, tag_we}, 0);
        check("rst_cmd_valid", {31'd0, cmd_valid}, 0);
        return;
      end
      check("refill_busy", {31'd0, req_ready}, 0);
      check("refill_data_way", {28'd0, data_way}, {28'd0, vic});
      rvalid = 1'b1;
      tick();
      rvalid = 1'b0;
      if (b == 1) begin
        tick();  // gap between rvalids: counter must hold
        check("gap_beat", {30'd0, data_beat}, 2);
      end
    end
    check("fill_tag_we", {31'd0, tag_we}, 1);
    check("fill_not_ready", {31'd0, req_ready}, 0);
    if (hold) done_q.push_back({4'd9, 4'b0010});
    tick();
    check("ready_after_fill", {31'd0, req_ready}, 1);
    if (hold) begin
      tick();
      req_valid = 1'b0;
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_index = '0; hit_way = '0;
    valid_way = '0; dirty_way = '0; killmask = '0;
    cmd_ready = 1'b0; wready = 1'b0; rvalid = 1'b0;
    tick(); tick();
    check("rst_req_ready", {31'd0, req_ready}, 1);
    check("rst_done", {31'd0, done}, 0);
    check("rst_touch", {31'd0, lru_touch}, 0);
    check("rst_cmd_valid0", {31'd0, cmd_valid}, 0);
    check("rst_wvalid", {31'd0, wvalid}, 0);
    check("rst_data_we", {31'd0, data_we}, 0);
    check("rst_tag_we0", {31'd0, tag_we}, 0);
    check("rst_data_way0", {28'd0, data_way}, 0);
    check("rst_data_beat0", {30'd0, data_beat}, 0);
    check("rst_lru_way", {28'd0, lru_way}, 0);
    rst = 1'b0;
    tick();

    // single hit, one-cycle latency
    req_valid = 1'b1; req_index = 4'd3; hit_way = 4'b0100; valid_way = 4'b1111;
    check("hit_ready", {31'd0, req_ready}, 1);
    done_q.push_back({4'd3, 4'b0100});
    tick();
    req_valid = 1'b0;
    check("hit_done_latency", {31'd0, done}, 1);
    check("hit_touch_index", {28'd0, lru_index}, 3);
    tick();

    // back-to-back hits, accepted every cycle
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_index = 4'(k + 5); hit_way = 4'(1 << k);
      check("b2b_ready", {31'd0, req_ready}, 1);
      done_q.push_back({4'(k + 5), 4'(1 << k)});
      tick();
    end
    req_valid = 1'b0; hit_way = 4'b0000;
    tick(); tick();

    // miss with a free way
    run_miss(4'd5, 4'b1011, 4'b0000, 4'b0001, 2, -1, -1, 1'b0);
    // full set, dirty LRU victim (writeback only when enabled)
    run_miss(4'd7, 4'b1111, 4'b0010, 4'b0010, 1, 2, -1, 1'b0);
    // multi-hot killmask, clean victim even though another way is dirty
    run_miss(4'd2, 4'b1111, 4'b1000, 4'b1010, 0, -1, -1, 1'b0);
    // request held during a miss
    run_miss(4'd10, 4'b0111, 4'b0000, 4'b0000, 1, -1, -1, 1'b1);
    // reset after refill beat 1
    run_miss(4'd12, 4'b1110, 4'b0000, 4'b0000, 0, -1, 2, 1'b0);

    // stray rvalid while idle must not write
    rvalid = 1'b1;
    check("stray_rvalid_we", {31'd0, data_we}, 0);
    tick();
    rvalid = 1'b0;
    tick();

    // clean miss after reset: counter restarts at 0
    run_miss(4'd15, 4'b1111, 4'b0000, 4'b0100, 0, -1, -1, 1'b0);

    tick(); tick(); tick();
    check("done_q_empty", done_q.size(), 0);
    check("beat_q_empty", beat_q.size(), 0);
    check("tag_q_empty", tag_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
